f1_light_sequencer: RTL

- Front-end controller for the F1 reaction challenge.
- On a start press, lights the LED gantry one lamp per step, then arms the downstream delay stage with a pseudo-random count.
- When the delay stage reports time-out, blanks all lamps and pulses `lights_out`, which starts reaction timing.
- Drives the delay stage's trigger/N inputs and consumes its time_out output.

---
 rtl/f1_pkg.sv | 21 ++
 rtl/f1_lfsr.sv | 27 ++
 rtl/f1_light_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// Shared constants for the F1 reaction-challenge light sequencer.
package f1_pkg;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_LIGHTING     = 3'd1,
      ST_HOLD         = 3'd2,
      ST_OUT          = 3'd3,
      ST_WAIT_RELEASE = 3'd4
   } state_t;

   localparam int          LFSR_W        = 14;
   // x^14 + x^13 + x^12 + x^2 + 1 -> feedback from bits 13, 12, 11, 1
   localparam logic [13:0] LFSR_TAPS     = 14'h3802;
   localparam logic [13:0] LFSR_SEED_DEF = 14'h2A5F;

   localparam int N_LEDS_DEF     = 10;
   localparam int BIT_SZ_DEF     = 14;
   localparam int STEP_TICKS_DEF = 500;

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR; a zero seed is replaced by 1 so it can never lock up.
module f1_lfsr
   import f1_pkg::*;
#(
   parameter int           W    = LFSR_W,
   parameter logic [W-1:0] TAPS = LFSR_TAPS,
   parameter logic [W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic         sysclk,
   input  logic         rst,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] SEED_G = (SEED == '0) ? W'(1) : SEED;

   logic [W-1:0] r_q;
   logic         w_fb;

   assign w_fb = ^(r_q & TAPS);
   assign q    = r_q;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) r_q <= SEED_G;
      else     r_q <= {r_q[W-2:0], w_fb};
   end

endmodule

// File: rtl/f1_light_sequencer.sv
// Lights the gantry lamp by lamp, arms the random delay stage, and blanks the
// lamps with a lights_out pulse when the delay stage times out.
module f1_light_sequencer
   import f1_pkg::*;
#(
   parameter int                N_LEDS     = N_LEDS_DEF,
   parameter int                BIT_SZ     = BIT_SZ_DEF,
   parameter int                STEP_TICKS = STEP_TICKS_DEF,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEF
) (
   input  logic              sysclk,
   input  logic              rst,
   input  logic              tick,
   input  logic              start,
   input  logic              time_out,
   output logic              delay_trigger,
   output logic [BIT_SZ-1:0] delay_n,
   output logic [N_LEDS-1:0] ledr,
   output logic              lights_out,
   output logic              busy,
   output logic [2:0]        state
);

   localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam int LIT_W  = $clog2(N_LEDS + 1);

   state_t              r_state,   w_state_nxt;
   logic [STEP_W-1:0]   r_step,    w_step_nxt;
   logic [LIT_W-1:0]    r_lit,     w_lit_nxt;
   logic [N_LEDS-1:0]   r_ledr,    w_ledr_nxt;
   logic                r_trig,    w_trig_nxt;
   logic [BIT_SZ-1:0]   r_dn,      w_dn_nxt;
   logic                r_lo,      w_lo_nxt;
   logic                r_start_d;
   logic                w_rise;
   logic [N_LEDS-1:0]   w_ledr_shift;
   logic [LFSR_W-1:0]   w_lfsr;

   f1_lfsr #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS),
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .sysclk (sysclk),
      .rst    (rst),
      .q      (w_lfsr)
   );

   generate
      if (N_LEDS == 1) begin : g_one
         assign w_ledr_shift = 1'b1;
      end else begin : g_many
         assign w_ledr_shift = {r_ledr[N_LEDS-2:0], 1'b1};
      end
   endgenerate

   assign w_rise        = start & ~r_start_d;
   assign delay_trigger = r_trig;
   assign delay_n       = r_dn;
   assign ledr          = r_ledr;
   assign lights_out    = r_lo;
   assign state         = r_state;
   assign busy          = (r_state != ST_IDLE);

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_step    <= '0;
         r_lit     <= '0;
         r_ledr    <= '0;
         r_trig    <= 1'b0;
         r_dn      <= '0;
         r_lo      <= 1'b0;
         r_start_d <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_step    <= w_step_nxt;
         r_lit     <= w_lit_nxt;
         r_ledr    <= w_ledr_nxt;
         r_trig    <= w_trig_nxt;
         r_dn      <= w_dn_nxt;
         r_lo      <= w_lo_nxt;
         r_start_d <= start;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_lit_nxt   = r_lit;
      w_ledr_nxt  = r_ledr;
      w_trig_nxt  = r_trig;
      w_dn_nxt    = r_dn;
      w_lo_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_LIGHTING;
               w_step_nxt  = '0;
               w_lit_nxt   = '0;
               w_ledr_nxt  = '0;
            end
         end
         ST_LIGHTING: begin
            if (tick) begin
               if (r_step != STEP_W'(STEP_TICKS - 1)) begin
                  w_step_nxt = r_step + 1'b1;
               end else begin
                  w_step_nxt = '0;
                  if (r_lit < LIT_W'(N_LEDS)) begin
                     w_ledr_nxt = w_ledr_shift;
                     w_lit_nxt  = r_lit + 1'b1;
                  end else begin
                     // one extra step after the last lamp before arming the delay
                     w_dn_nxt    = w_lfsr[BIT_SZ-1:0];
                     w_trig_nxt  = 1'b1;
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (time_out) begin
               w_ledr_nxt  = '0;
               w_lo_nxt    = 1'b1;
               w_trig_nxt  = 1'b0;
               w_state_nxt = ST_OUT;
            end
         end
         ST_OUT:          w_state_nxt = ST_WAIT_RELEASE;
         ST_WAIT_RELEASE: if (!start) w_state_nxt = ST_IDLE;
         default:         w_state_nxt = ST_IDLE;
      endcase
   end

endmodule
